// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus MMIO timer/compare IRQ and a byte TX FIFO.
// Optional build macro TX_OVF_STICKY_EN adds a sticky FIFO overflow flag at STATUS bit3.
module dmem_mmio #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam logic [7:0] OFF_TIMER  = 8'h00;
  localparam logic [7:0] OFF_CMP    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_TXDATA = 8'h0C;

  logic [31:0] ram [2**RAM_AW];
  logic [7:0]  fifo_mem [2**FIFO_AW];

  logic              mmio_sel, ram_sel, wr_en, rd_en;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        off;
  logic              wr_timer, wr_cmp, wr_status, push_req, push, pop;
  logic [31:0]       timer, cmp, status, mmio_rdata;
  logic              irq_pending, ovf_flag;
  logic [FIFO_AW:0]  wptr, rptr, count;
  logic              full, empty;
  logic              addr_unused;

  assign mmio_sel = (addr[31:28] == MMIO_BASE[31:28]);
  assign ram_sel  = ~mmio_sel;
  assign ram_idx  = addr[RAM_AW+1:2];
  assign off      = addr[7:0];
  assign addr_unused = ^addr[27:RAM_AW+2];

  // Accesses presented while reset is asserted must not disturb any state.
  assign wr_en = ce & we & ~rst;
  assign rd_en = ce & ~we;

  assign wr_timer  = wr_en & mmio_sel & (off == OFF_TIMER);
  assign wr_cmp    = wr_en & mmio_sel & (off == OFF_CMP);
  assign wr_status = wr_en & mmio_sel & (off == OFF_STATUS);
  assign push_req  = wr_en & mmio_sel & (off == OFF_TXDATA);

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= 32'd0;
      cmp         <= 32'hFFFF_FFFF;
      irq_pending <= 1'b0;
    end else begin
      timer <= wr_timer ? wdata : timer + 32'd1;
      if (wr_cmp) cmp <= wdata;
      if (timer == cmp)                irq_pending <= 1'b1;
      else if (wr_status && wdata[0])  irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign push  = push_req & ~full;
  assign pop   = ~empty & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[FIFO_AW-1:0]] <= wdata[7:0];
  end

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rptr[FIFO_AW-1:0]];

`ifdef TX_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst)                        ovf_flag <= 1'b0;
    else if (push_req && full)      ovf_flag <= 1'b1;
    else if (wr_status && wdata[3]) ovf_flag <= 1'b0;
  end
`else
  assign ovf_flag = 1'b0;
`endif

  always_comb begin
    status              = '0;
    status[0]           = irq_pending;
    status[1]           = full;
    status[2]           = empty;
    status[3]           = ovf_flag;
    status[8 +: FIFO_AW+1] = count;
  end

  always_comb begin
    case (off)
      OFF_TIMER:  mmio_rdata = timer;
      OFF_CMP:    mmio_rdata = cmp;
      OFF_STATUS: mmio_rdata = status;
      default:    mmio_rdata = 32'd0;
    endcase
  end

  assign rdata = rd_en ? (mmio_sel ? mmio_rdata : ram[ram_idx]) : 32'd0;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: table-driven access vectors plus directed timer/FIFO/reset sequences.
module tb_dmem_mmio;

  localparam logic [31:0] A_TIMER  = 32'h1000_0000;
  localparam logic [31:0] A_CMP    = 32'h1000_0004;
  localparam logic [31:0] A_STATUS = 32'h1000_0008;
  localparam logic [31:0] A_TXDATA = 32'h1000_000C;

  logic        clk, rst, ce, we, tx_ready;
  logic [31:0] addr, wdata, rdata;
  logic        tx_valid, irq;
  logic [7:0]  tx_data;

  int n_total = 0;
  int n_pass  = 0;

  dmem_mmio dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; addr = a; wdata = d;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'd0);
    chk(name, rdata, exp);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  logic [31:0] t;
  logic [31:0] exp_full_status;
  bit          found;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          "ram_wr_rdata0"};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  "ram_rd_aligned"};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF,  "ram_rd_misaligned"};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,          "ram_rd_ce0"};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF,  "ram_alias"};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 32'h0,          "ram_wr2"};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,         32'h0BAD_F00D,  "ram_rd2"};
    vecs[7]  = '{1'b1, 1'b0, A_CMP,         32'h0,         32'hFFFF_FFFF,  "cmp_reset"};
    vecs[8]  = '{1'b1, 1'b0, A_TXDATA,      32'h0,         32'h0,          "txdata_rd0"};
    vecs[9]  = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         32'h0,          "unmapped_rd"};
    vecs[10] = '{1'b1, 1'b1, 32'h1000_0010, 32'h5,         32'h0,          "unmapped_wr"};
    vecs[11] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         32'h0,          "unmapped_rd2"};
    vecs[12] = '{1'b1, 1'b0, 32'h2000_0010, 32'h0,         32'hDEAD_BEEF,  "ram_hi_alias"};

`ifdef TX_OVF_STICKY_EN
    exp_full_status = 32'h0000_080A;
`else
    exp_full_status = 32'h0000_0802;
`endif

    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rd_chk("rst_timer", A_TIMER, 32'd0);
    rd_chk("rst_status", A_STATUS, 32'h0000_0004);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk(vecs[i].name, rdata, vecs[i].exp);
      tick();
    end

    // Timer reaches CMP=20; irq rises on the following edge.
    wr(A_TIMER, 32'd0);
    wr(A_CMP, 32'd20);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b1, 1'b0, A_TIMER, 32'd0);
      t = rdata;
      if (t == 32'd20) begin
        found = 1;
        chk("irq_before_match", {31'd0, irq}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("irq_after_match", {31'd0, irq}, 32'd1);
      end
      tick();
    end
    if (!found) chk("timer_reach_cmp_timeout", t, 32'd20);
    wr(A_STATUS, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr(A_TIMER, 32'hFFFF_FFFF);
    rd_chk("timer_loaded", A_TIMER, 32'hFFFF_FFFF);
    rd_chk("timer_wrapped", A_TIMER, 32'd0);
    wr(A_CMP, 32'hFFFF_FFFF);

    // Fill FIFO with sink stalled; the ninth push is dropped.
    tx_ready = 1'b0;
    drive(1'b1, 1'b1, A_TXDATA, 32'h41);
    chk("push_empty_valid_now", {31'd0, tx_valid}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("push_empty_valid_next", {31'd0, tx_valid}, 32'd1);
    for (int i = 1; i < 9; i++) wr(A_TXDATA, 32'h41 + i);
    rd_chk("fifo_full_status", A_STATUS, exp_full_status);
    chk("fifo_full_head", {24'd0, tx_data}, 32'h41);

    // Drain one byte per cycle.
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain_byte%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h41 + 8'(i)});
      tick();
    end
    chk("drain_valid_low", {31'd0, tx_valid}, 32'd0);
    rd_chk("drain_status", A_STATUS, exp_full_status[3] ? 32'h0000_000C : 32'h0000_0004);
    wr(A_STATUS, 32'h8);
    rd_chk("ovf_clear_status", A_STATUS, 32'h0000_0004);

    // Simultaneous push and pop with three entries queued.
    tx_ready = 1'b0;
    wr(A_TXDATA, 32'h50);
    wr(A_TXDATA, 32'h51);
    wr(A_TXDATA, 32'h52);
    rd_chk("three_status", A_STATUS, 32'h0000_0300);
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h53);
    tx_ready = 1'b0;
    rd_chk("pushpop_status", A_STATUS, 32'h0000_0300);
    chk("pushpop_head", {24'd0, tx_data}, 32'h51);
    tx_ready = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pp_drain%0d", i), {24'd0, tx_data}, 32'h51 + i);
      tick();
    end
    chk("pp_empty", {31'd0, tx_valid}, 32'd0);

    // Reset in the middle of traffic with irq pending.
    tx_ready = 1'b0;
    wr(32'h0000_0040, 32'h1234_5678);
    for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'h61 + i);
    wr(A_CMP, 32'd500);
    wr(A_TIMER, 32'd500);
    idle();
    rd_chk("pre_rst_status", A_STATUS, 32'h0000_0501);
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0040, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    rd_chk("mid_rst_timer", A_TIMER, 32'd0);
    rd_chk("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("mid_rst_ram", 32'h0000_0040, 32'h1234_5678);
    rd_chk("mid_rst_status", A_STATUS, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side memory subsystem that sits directly downstream of the single-cycle core's data port. It consumes ce/we/address/store-data and returns load data in the same cycle. It decodes each access to either a word-addressed data RAM or a small MMIO register file. The MMIO space holds a free-running timer with a compare interrupt and a byte TX FIFO that drains to a debug console over a valid/ready handshake.

Parameters:
RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
FIFO_AW, 3, log2 of TX FIFO depth (default 8 entries)
MMIO_BASE, 32'h1000_0000, MMIO region base; region is selected by addr[31:28] == MMIO_BASE[31:28]

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
ce  in  1  access enable from core (data_ce_o)
we  in  1  write enable from core (data_we_o); meaningful only when ce=1
addr  in  32  byte address from core (data_addr_o)
wdata  in  32  store data from core (data_o)
rdata  out  32  load data to core (data_i); combinational
tx_valid  out  1  TX FIFO head is valid
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  console sink accepts head byte this cycle
irq  out  1  timer compare interrupt pending (level)

Behaviour:
- Decode: MMIO select when addr[31:28] == MMIO_BASE[31:28]; all other addresses are RAM. RAM word index = addr[RAM_AW+1:2]. Upper address bits alias. addr[1:0] is ignored, so misaligned accesses act as aligned.
- RAM: write on the clock edge when ce & we & ram_sel. Read is combinational (zero latency, as the single-cycle core requires). RAM contents are not reset.
- rdata = 0 when ce=0 or we=1. Otherwise rdata = RAM word or MMIO register value, as selected.
- MMIO map, offset = addr[7:0]:
  - 0x00 TIMER, R/W: increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. A write loads wdata; when a write and an increment coincide, the write wins and the next increment starts from the written value.
  - 0x04 CMP, R/W: reset value 32'hFFFF_FFFF.
  - 0x08 STATUS: bit0 irq_pending, bit1 fifo_full, bit2 fifo_empty, bit3 0 (see optional feature), bits[8+FIFO_AW:8] fifo count, all other bits 0. Writing 1 to bit0 clears irq_pending; all other bits are read-only.
  - 0x0C TXDATA, W: pushes wdata[7:0]. Reads return 0.
  - Unmapped offsets read 0; writes to them are ignored.
- irq_pending sets on the edge after any cycle in which TIMER == CMP. If set and clear occur in the same cycle, set wins. irq = irq_pending.
- TX FIFO (circular buffer; read/write pointers of FIFO_AW+1 bits; full/empty derived from the pointers):
  - push when ce & we & TXDATA selected & !full. A push while full is dropped, even if a pop happens in the same cycle.
  - pop when tx_valid & tx_ready.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Push into an empty FIFO: tx_valid rises on the next cycle (no bypass).
  - tx_valid = !empty; tx_data = head entry, held stable until popped.
- Reset (synchronous, rst=1 at a rising edge): TIMER=0, CMP=FFFF_FFFF, irq_pending=0, FIFO pointers=0. Resulting outputs: tx_valid=0, irq=0, tx_data=0. Reset asserted mid-drain discards all FIFO contents. RAM is unaffected. Accesses during reset are ignored.

Optional Feature:
TX_OVF_STICKY_EN: when defined, STATUS bit3 is a sticky overflow flag. It sets when a push is dropped because the FIFO is full. Writing 1 to bit3 clears it; set wins over a same-cycle clear; reset clears it. When undefined, bit3 reads 0 and dropped pushes leave no trace.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF in the same cycle; read with ce=0 -> rdata=0.
- Timer/irq: after reset, write CMP=20, then poll TIMER -> irq rises the cycle after TIMER reads 20. Write STATUS=1 -> irq=0 next cycle. Write TIMER=0xFFFF_FFFF -> TIMER reads 0 the following cycle.
- FIFO fill with tx_ready=0: push 0x41..0x49 (9 bytes) -> STATUS shows full=1, count=8; tx_data=0x41; 0x49 dropped. With TX_OVF_STICKY_EN, bit3=1.
- Drain with tx_ready=1: sink receives 0x41..0x48 in order, one byte per cycle. tx_valid then falls and STATUS shows empty=1.
- Simultaneous push/pop with 3 entries, tx_ready=1 -> count stays 3 and head advances. Push into empty FIFO -> tx_valid=0 in the push cycle, 1 in the next.
- Reset mid-operation: 5 entries queued, irq pending, rst=1 for one edge -> tx_valid=0, irq=0, TIMER reads 0/1, CMP reads 0xFFFF_FFFF, previously written RAM word unchanged.
